spi_ram_burst: RTL and testbench

- Parametrised successor of the SPI-slave single-port RAM.
- Decodes 2-bit-opcode command words from the SPI slave front end, and holds separate write and read address pointers.
- New behaviour: optional auto-increment of both pointers for burst transfers, a held read-data handshake (tx_valid/tx_ready), and sticky error flags for overrun and out-of-range access.
- Sits between the SPI slave shift logic and the wrapper top.

---
 rtl/spi_ram_pkg.sv | 22 ++
 rtl/spi_ram_ptr.sv | 34 +++
 rtl/spi_ram_burst.sv | 113 +++++++++++
 tb/tb_spi_ram_burst.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared opcode encoding and parameter sanity helpers for the SPI RAM burst block.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } opcode_e;

    // Pointers are loaded from the payload, and must be able to address every word.
    function automatic bit params_ok(input int addr_width, input int data_width,
                                     input int mem_depth);
        return (addr_width <= data_width) && (mem_depth >= 2) &&
               (longint'(mem_depth) <= (longint'(1) << addr_width));
    endfunction

    function automatic bit out_of_range(input int unsigned value, input int unsigned depth);
        return value >= depth;
    endfunction

endpackage

// File: rtl/spi_ram_ptr.sv
// Address pointer with load, optional increment that wraps at MEM_DEPTH-1,
// and a single-cycle range-error strobe when an out-of-range value is loaded.
module spi_ram_ptr
    import spi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_val,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  range_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

    assign range_err = load && out_of_range(32'(load_val), MEM_DEPTH);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/spi_ram_burst.sv
// Command decoder, single-port RAM and held read-data register for the SPI slave path,
// with optional pointer auto-increment and sticky overrun / address-range flags.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter bit AUTO_INC   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH+1:0] din,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  tx_valid,
    output logic                  ovf_err,
    output logic                  addr_err
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    if (!params_ok(ADDR_WIDTH, DATA_WIDTH, MEM_DEPTH)) begin : g_bad_params
        $error("spi_ram_burst: need ADDR_WIDTH <= DATA_WIDTH and 2 <= MEM_DEPTH <= 2**ADDR_WIDTH");
    end

    opcode_e               op;
    logic [DATA_WIDTH-1:0] payload;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_range_err;
    logic                  rd_range_err;
    logic                  wr_cmd;
    logic                  rd_cmd;
    logic                  out_free;
    logic                  rd_accept;
    logic                  rd_drop;
    logic                  wr_in_range;
    logic                  rd_in_range;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    assign op      = opcode_e'(din[DATA_WIDTH+1:DATA_WIDTH]);
    assign payload = din[DATA_WIDTH-1:0];

    assign wr_cmd    = rx_valid && (op == WR_DATA);
    assign rd_cmd    = rx_valid && (op == RD_DATA);
    // A read command may reuse the output register in the same cycle it is being drained.
    assign out_free  = !tx_valid || tx_ready;
    assign rd_accept = rd_cmd && out_free;
    assign rd_drop   = rd_cmd && !out_free;

    assign wr_in_range = !out_of_range(32'(wr_ptr), MEM_DEPTH);
    assign rd_in_range = !out_of_range(32'(rd_ptr), MEM_DEPTH);

    spi_ram_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_wr_ptr (
        .clk       (clk),
        .rst       (rst),
        .load      (rx_valid && (op == WR_ADDR)),
        .load_val  (payload[ADDR_WIDTH-1:0]),
        .inc       (AUTO_INC && wr_cmd),
        .ptr       (wr_ptr),
        .range_err (wr_range_err)
    );

    spi_ram_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_rd_ptr (
        .clk       (clk),
        .rst       (rst),
        .load      (rx_valid && (op == RD_ADDR)),
        .load_val  (payload[ADDR_WIDTH-1:0]),
        .inc       (AUTO_INC && rd_accept),
        .ptr       (rd_ptr),
        .range_err (rd_range_err)
    );

    // NOTE: the memory array has no reset so it maps onto RAM primitives;
    // its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_cmd && wr_in_range) begin
            mem[wr_ptr[IDX_W-1:0]] <= payload;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout     <= '0;
            tx_valid <= 1'b0;
            ovf_err  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            if (rd_accept) begin
                dout     <= rd_in_range ? mem[rd_ptr[IDX_W-1:0]] : '0;
                tx_valid <= 1'b1;
            end else if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end
            if (rd_drop) begin
                ovf_err <= 1'b1;
            end
            if (wr_range_err || rd_range_err) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench: default burst config, a 200-word config, and a static-pointer config.
module tb_spi_ram_burst;
    import spi_ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid [3];
    logic [9:0] din      [3];
    logic       tx_ready [3];
    logic [7:0] dout     [3];
    logic       tx_valid [3];
    logic       ovf_err  [3];
    logic       addr_err [3];

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    spi_ram_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[0]), .din(din[0]), .tx_ready(tx_ready[0]),
        .dout(dout[0]), .tx_valid(tx_valid[0]), .ovf_err(ovf_err[0]), .addr_err(addr_err[0])
    );

    spi_ram_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[1]), .din(din[1]), .tx_ready(tx_ready[1]),
        .dout(dout[1]), .tx_valid(tx_valid[1]), .ovf_err(ovf_err[1]), .addr_err(addr_err[1])
    );

    spi_ram_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[2]), .din(din[2]), .tx_ready(tx_ready[2]),
        .dout(dout[2]), .tx_valid(tx_valid[2]), .ovf_err(ovf_err[2]), .addr_err(addr_err[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; presents one command for the next rising edge and
    // returns at the following falling edge, where its effect is visible.
    task automatic cmd(input int d, input opcode_e op, input logic [7:0] pl);
        rx_valid[d] = 1'b1;
        din[d]      = {op, pl};
        @(negedge clk);
        rx_valid[d] = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input int d, input logic [7:0] exp_dout,
                             input logic exp_valid);
        check({tag, ".dout"}, 32'(dout[d]), 32'(exp_dout));
        check({tag, ".tx_valid"}, 32'(tx_valid[d]), 32'(exp_valid));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rx_valid[i] = 1'b0;
            din[i]      = '0;
            tx_ready[i] = 1'b1;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle();

        check_out("reset", 0, 8'h00, 1'b0);
        check("reset.ovf_err", 32'(ovf_err[0]), 32'd0);
        check("reset.addr_err", 32'(addr_err[0]), 32'd0);

        // Write burst wrapping past the top of a 256-word memory.
        cmd(0, WR_ADDR, 8'hFE);
        cmd(0, WR_DATA, 8'h11);
        cmd(0, WR_DATA, 8'h22);
        cmd(0, WR_DATA, 8'h33);

        // Read burst with the consumer always ready.
        cmd(0, RD_ADDR, 8'hFE);
        check_out("burst.pre", 0, 8'h00, 1'b0);
        cmd(0, RD_DATA, 8'h00);
        check_out("burst.rd0", 0, 8'h11, 1'b1);
        cmd(0, RD_DATA, 8'h00);
        check_out("burst.rd1", 0, 8'h22, 1'b1);
        cmd(0, RD_DATA, 8'h00);
        check_out("burst.rd2_wrap", 0, 8'h33, 1'b1);
        idle();
        check_out("burst.drain", 0, 8'h33, 1'b0);
        check("burst.ovf_err", 32'(ovf_err[0]), 32'd0);

        // Backpressure: second read dropped, pointer advances once.
        tx_ready[0] = 1'b0;
        cmd(0, RD_ADDR, 8'hFE);
        cmd(0, RD_DATA, 8'h00);
        check_out("bp.first", 0, 8'h11, 1'b1);
        check("bp.ovf_before", 32'(ovf_err[0]), 32'd0);
        cmd(0, RD_DATA, 8'h00);
        check_out("bp.dropped", 0, 8'h11, 1'b1);
        check("bp.ovf_err", 32'(ovf_err[0]), 32'd1);
        idle();
        check_out("bp.held", 0, 8'h11, 1'b1);
        tx_ready[0] = 1'b1;
        idle();
        check_out("bp.accepted", 0, 8'h11, 1'b0);
        tx_ready[0] = 1'b0;
        cmd(0, RD_DATA, 8'h00);
        check_out("bp.next_ptr", 0, 8'h22, 1'b1);
        check("bp.ovf_sticky", 32'(ovf_err[0]), 32'd1);
        check("bp.addr_err", 32'(addr_err[0]), 32'd0);

        // MEM_DEPTH=200: wrap at 199, out-of-range loads flag and read as zero.
        cmd(1, WR_ADDR, 8'hC7);
        check("d200.addr_ok", 32'(addr_err[1]), 32'd0);
        cmd(1, WR_DATA, 8'h77);
        cmd(1, WR_DATA, 8'h99);
        cmd(1, RD_ADDR, 8'hC7);
        cmd(1, RD_DATA, 8'h00);
        check_out("d200.rd_last", 1, 8'h77, 1'b1);
        cmd(1, RD_DATA, 8'h00);
        check_out("d200.rd_wrap", 1, 8'h99, 1'b1);
        cmd(1, WR_ADDR, 8'hC8);
        check("d200.addr_err", 32'(addr_err[1]), 32'd1);
        check("d200.tx_drain", 32'(tx_valid[1]), 32'd0);
        cmd(1, WR_DATA, 8'h5A);
        cmd(1, RD_ADDR, 8'hC8);
        cmd(1, RD_DATA, 8'h00);
        check_out("d200.rd_oor", 1, 8'h00, 1'b1);
        check("d200.addr_sticky", 32'(addr_err[1]), 32'd1);
        check("d200.ovf_err", 32'(ovf_err[1]), 32'd0);

        // AUTO_INC=0: pointers stay put.
        cmd(2, WR_ADDR, 8'h11);
        cmd(2, WR_DATA, 8'h5C);
        cmd(2, WR_ADDR, 8'h10);
        cmd(2, WR_DATA, 8'hAA);
        cmd(2, WR_DATA, 8'hBB);
        cmd(2, RD_ADDR, 8'h10);
        cmd(2, RD_DATA, 8'h00);
        check_out("static.rd", 2, 8'hBB, 1'b1);
        cmd(2, RD_DATA, 8'h00);
        check_out("static.rd_again", 2, 8'hBB, 1'b1);
        cmd(2, RD_ADDR, 8'h11);
        cmd(2, RD_DATA, 8'h00);
        check_out("static.neighbour", 2, 8'h5C, 1'b1);

        // Asynchronous reset between clock edges clears everything immediately.
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst.d0", 0, 8'h00, 1'b0);
        check("async_rst.ovf_err", 32'(ovf_err[0]), 32'd0);
        check_out("async_rst.d1", 1, 8'h00, 1'b0);
        check("async_rst.addr_err", 32'(addr_err[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
